arbitro_mux2a1_ochobits: RTL
============================

ARBITRO_MUX2A1_OCHOBITS -- requirements
Module: arbitro_mux2a1_ochobits

Interface
REQ-001 Parameter: BW, 8, data width in bits of each channel and of the output.
REQ-002 Parameter: DEPTH, 4, entries per input FIFO; power of two, minimum 2.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset_L  input  1  reset, synchronous and active-low, sampled on clk rising edge.
REQ-005 Port: valid0 / data_in0  input  1 / BW  channel-0 write strobe and byte.
REQ-006 Port: valid1 / data_in1  input  1 / BW  channel-1 write strobe and byte.
REQ-007 Port: pausa  input  1  downstream back-pressure; 1 = no byte may be issued this cycle.
REQ-008 Port: full0 / full1  output  1 / 1  channel FIFO holds DEPTH entries.
REQ-009 Port: selector  output  1  index of the channel that supplied the current data_out.
REQ-010 Port: valid_out / data_out  output  1 / BW  registered output strobe and byte.
REQ-011 Port: error_out  output  1  one-cycle pulse: a write was attempted into a full FIFO.

Function
REQ-012 Each channel k SHALL own a DEPTH-entry FIFO; write when valid_k=1 and full_k=0 at a clk edge.
REQ-013 full_k SHALL derive from the registered occupancy only; a same-cycle pop does not unblock a write to a full FIFO.
REQ-014 valid_k=1 while full_k=1 SHALL drop the byte, leave pointers unchanged, and set error_out=1 for the following cycle only; both channels overflowing together give a single pulse.
REQ-015 Arbiter FSM states: IDLE (no grant), SERV0, SERV1; state updates every edge.
REQ-016 Next state IDLE when pausa=1 or both FIFOs empty (registered occupancy).
REQ-017 Only one FIFO non-empty and pausa=0: next state serves that channel.
REQ-018 Both non-empty and pausa=0: next state serves the channel not served last (round-robin via last-grant register).
REQ-019 Entering SERVk SHALL pop FIFO k on that edge and register valid_out=1, data_out=popped byte, selector=k.
REQ-020 Entering IDLE: valid_out=0; data_out and selector SHALL hold their previous values.
REQ-021 Sustained throughput: one byte per cycle while pausa=0 and data is available; both channels saturated alternate 0,1,0,1...
REQ-022 Latency: byte written at edge E into an empty system with pausa=0 SHALL appear with valid_out=1 after edge E+1.
REQ-023 Simultaneous push and pop on the same FIFO SHALL keep occupancy unchanged and preserve FIFO order.
REQ-024 Pointers SHALL wrap modulo DEPTH; occupancy counter spans 0..DEPTH.

Reset
REQ-025 reset_L=0 at an edge SHALL set state=IDLE, pointers and occupancy=0, last-grant=1 (channel 0 wins first tie).
REQ-026 Reset values: valid_out=0, data_out=0, selector=0, error_out=0, full0=0, full1=0.
REQ-027 Writes and pops SHALL be ignored while reset_L=0; reset mid-transfer discards all stored bytes.

Configuration
REQ-028 Macro FIXED_PRIORITY_EN defined: REQ-018 replaced by strict priority, channel 0 always wins when non-empty.
REQ-029 Macro FIXED_PRIORITY_EN undefined: round-robin per REQ-018; last-grant register present.

Verification
REQ-030 Reset then valid0=1, data_in0=8'hA5 one cycle, pausa=0 -> after second edge valid_out=1, data_out=8'hA5, selector=0, next cycle valid_out=0.
REQ-031 Load ch0 with 11,12,13 and ch1 with 21,22,23 under pausa=1, then pausa=0 -> data_out sequence 11,21,12,22,13,23 (with FIXED_PRIORITY_EN: 11,12,13,21,22,23).
REQ-032 Write 5 bytes to ch1 with DEPTH=4, pausa=1 -> full1=1 after 4th; 5th dropped, error_out=1 one cycle; drain yields only first 4 bytes.
REQ-033 Stream alternating data on both channels, toggle pausa every 3 cycles -> no valid_out during pause cycles, no loss, order per channel preserved.
REQ-034 Fill ch0 with 3 bytes, assert reset_L=0 one cycle mid-drain -> all outputs at reset values, no further valid_out until new writes.

Source files
------------

// File: rtl/arbitro_mux2a1_ochobits_if.sv
// -----------------------------------------------------------------------------
// arbitro_mux2a1_ochobits_if
// Bundles the two write channels, the back-pressure input and the arbitrated
// output of arbitro_mux2a1_ochobits.
//   slave  : the arbiter's view (channels and pausa in; flags and output out)
//   master : the environment's view (drives channels and pausa)
// Signals:
//   valid0/data_in0, valid1/data_in1 : per-channel write strobe and byte
//   pausa                            : downstream back-pressure
//   full0/full1                      : channel FIFO holds DEPTH entries
//   selector, valid_out, data_out    : registered arbitrated output
//   error_out                        : one-cycle overflow pulse
// -----------------------------------------------------------------------------
interface arbitro_mux2a1_ochobits_if #(
  parameter int BW = 8
);
  logic          valid0;
  logic [BW-1:0] data_in0;
  logic          valid1;
  logic [BW-1:0] data_in1;
  logic          pausa;
  logic          full0;
  logic          full1;
  logic          selector;
  logic          valid_out;
  logic [BW-1:0] data_out;
  logic          error_out;

  modport slave (
    input  valid0, data_in0, valid1, data_in1, pausa,
    output full0, full1, selector, valid_out, data_out, error_out
  );

  modport master (
    output valid0, data_in0, valid1, data_in1, pausa,
    input  full0, full1, selector, valid_out, data_out, error_out
  );
endinterface

// File: rtl/arbitro_mux2a1_ochobits.sv
// -----------------------------------------------------------------------------
// arbitro_mux2a1_ochobits
// Two-channel byte arbiter: each channel writes into its own DEPTH-entry FIFO,
// and a three-state FSM (IDLE/SERV0/SERV1) issues at most one byte per cycle
// on a registered output, honouring downstream back-pressure (pausa).
// Ports:
//   clk      : single clock, all state on rising edge
//   reset_L  : synchronous active-low reset
//   bus      : arbitro_mux2a1_ochobits_if.slave (channels, pausa, flags, output)
// Configuration macro:
//   FIXED_PRIORITY_EN : when defined, channel 0 always wins a tie; otherwise
//                       ties are resolved round-robin with a last-grant register.
// -----------------------------------------------------------------------------
module arbitro_mux2a1_ochobits #(
  parameter int BW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_L,
  arbitro_mux2a1_ochobits_if.slave      bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;   // occupancy spans 0..DEPTH

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERV0 = 2'd1,
    SERV1 = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             vin;
  logic [1:0][BW-1:0]     din;
  logic [1:0]             push;
  logic [1:0]             pop;
  logic [1:0]             full;
  logic [1:0]             not_empty;
  logic [1:0]             grant;
  logic [1:0][BW-1:0]     rd_data;

  logic [BW-1:0]          data_out_q, data_out_d;
  logic                   selector_q, selector_d;
  logic                   error_q, error_d;

  assign vin = {bus.valid1, bus.valid0};
  assign din = {bus.data_in1, bus.data_in0};

  // ---------------------------------------------------------------------------
  // Per-channel FIFOs
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [BW-1:0] mem_q [DEPTH];
      logic [AW-1:0] wr_ptr_q, wr_ptr_d;
      logic [AW-1:0] rd_ptr_q, rd_ptr_d;
      logic [CW-1:0] cnt_q, cnt_d;

      // full comes from registered occupancy only, so a pop in the same
      // cycle never lets a write into a full FIFO.
      assign full[gi]      = (cnt_q == CW'(DEPTH));
      assign not_empty[gi] = (cnt_q != '0);
      assign push[gi]      = reset_L & vin[gi] & ~full[gi];
      assign pop[gi]       = reset_L & grant[gi];
      assign rd_data[gi]   = mem_q[rd_ptr_q];

      always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        // DEPTH is a power of two, so the natural pointer wrap is modulo DEPTH.
        if (push[gi]) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop[gi])  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push[gi], pop[gi]})
          2'b10:   cnt_d = cnt_q + CW'(1);
          2'b01:   cnt_d = cnt_q - CW'(1);
          default: cnt_d = cnt_q;
        endcase
      end

      // Storage carries no reset so it maps onto plain RAM.
      always_ff @(posedge clk) begin
        if (push[gi]) mem_q[wr_ptr_q] <= din[gi];
      end

      always_ff @(posedge clk) begin
        if (!reset_L) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          cnt_q    <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          cnt_q    <= cnt_d;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Arbiter FSM
  // ---------------------------------------------------------------------------
`ifndef FIXED_PRIORITY_EN
  // Last channel granted; resets to 1 so channel 0 wins the first tie.
  logic last_q, last_d;
`endif

  always_comb begin
    state_d = IDLE;
    if (!bus.pausa) begin
      case (not_empty)
        2'b01:   state_d = SERV0;
        2'b10:   state_d = SERV1;
        2'b11: begin
`ifdef FIXED_PRIORITY_EN
          state_d = SERV0;
`else
          state_d = last_q ? SERV0 : SERV1;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
    grant[0] = (state_d == SERV0);
    grant[1] = (state_d == SERV1);
  end

  always_ff @(posedge clk) begin
    if (!reset_L) state_q <= IDLE;
    else          state_q <= state_d;
  end

`ifndef FIXED_PRIORITY_EN
  always_comb begin
    last_d = last_q;
    if (grant[0]) last_d = 1'b0;
    if (grant[1]) last_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_L) last_q <= 1'b1;
    else          last_q <= last_d;
  end
`endif

  // ---------------------------------------------------------------------------
  // Output registers: data_out/selector hold their values across IDLE.
  // ---------------------------------------------------------------------------
  always_comb begin
    data_out_d = data_out_q;
    selector_d = selector_q;
    if (grant[0]) begin
      data_out_d = rd_data[0];
      selector_d = 1'b0;
    end else if (grant[1]) begin
      data_out_d = rd_data[1];
      selector_d = 1'b1;
    end
    // A simultaneous overflow on both channels still yields one pulse.
    error_d = |(vin & full);
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      data_out_q <= '0;
      selector_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      selector_q <= selector_d;
      error_q    <= error_d;
    end
  end

  // valid_out is exactly "the FSM sits in a serving state".
  assign bus.valid_out = (state_q != IDLE);
  assign bus.data_out  = data_out_q;
  assign bus.selector  = selector_q;
  assign bus.error_out = error_q;
  assign bus.full0     = full[0];
  assign bus.full1     = full[1];

endmodule
